// File: rtl/knn_ctrl_pkg.sv
// rtl/knn_ctrl_pkg.sv - shared types and constants for the KNN sequencing controller
package knn_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM,
    S_LOAD_REF,
    S_LOAD_TRAIN,
    S_DRAIN,
    S_FINISH,
    S_READ_REQ,
    S_READ_HOLD,
    S_ERR
  } state_t;

  localparam int VEC_CNT_W            = 16;
  localparam int PERF_W               = 32;
  localparam int DEFAULT_DRAIN_CYCLES = 10;

  // Bits needed to index n distinct values, never less than one.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/knn_beat_counter.sv
// rtl/knn_beat_counter.sv - beat-within-vector counter with wrap and saturating vector counter
module knn_beat_counter
  import knn_ctrl_pkg::*;
#(
  parameter int numberOfDimensions = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clear,
  input  logic                 i_beat,
  input  logic                 i_vec_en,
  output logic [VEC_CNT_W-1:0] o_vec_cnt,
  output logic                 o_vec_end,
  output logic                 o_beat_first
);

  localparam int BW = cnt_width(numberOfDimensions);
  localparam logic [BW-1:0] LAST_BEAT = BW'(numberOfDimensions - 1);

  logic [BW-1:0]        r_beat;
  logic [VEC_CNT_W-1:0] r_vec;

  assign o_vec_end    = (r_beat == LAST_BEAT);
  assign o_beat_first = (r_beat == '0);
  assign o_vec_cnt    = r_vec;

  // Beat position inside the current vector, wrapping after the last dimension
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_beat <= '0;
    end else if (i_beat) begin
      r_beat <= o_vec_end ? '0 : r_beat + 1'b1;
    end
  end

  // Completed training vectors, pinned at all-ones rather than wrapping
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_vec <= '0;
    end else if (i_beat && o_vec_end && i_vec_en && (r_vec != '1)) begin
      r_vec <= r_vec + 1'b1;
    end
  end

endmodule

// File: rtl/knn_seq_ctrl.sv
// rtl/knn_seq_ctrl.sv - KNN core sequencer; KNN_CTRL_PERF_EN adds perf_cycles/perf_vectors
module knn_seq_ctrl
  import knn_ctrl_pkg::*;
#(
  parameter int dataWidth          = 32,
  parameter int numberOfDimensions = 5,
  parameter int numberOfChannels   = 2,
  parameter int k                  = 3,
  parameter int drainCycles        = DEFAULT_DRAIN_CYCLES
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   cmd_start,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [numberOfChannels*dataWidth-1:0]  in_data,
  input  logic                                   in_last,
  output logic                                   core_start,
  output logic                                   core_wr_en,
  output logic [numberOfChannels*dataWidth-1:0]  core_dataValueIn,
  output logic                                   core_done,
  output logic                                   core_rd_en,
  input  logic [31:0]                            core_dataNameOut,
  input  logic [31:0]                            core_dataValueOut,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [31:0]                            out_name,
  output logic [31:0]                            out_value,
  output logic                                   out_last,
  output logic                                   busy,
  output logic                                   error
`ifdef KNN_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]                      perf_cycles,
  output logic [PERF_W-1:0]                      perf_vectors
`endif
);

  localparam int DW  = numberOfChannels * dataWidth;
  localparam int DCW = cnt_width(drainCycles + 1);
  localparam int KW  = cnt_width(k);
  localparam logic [DCW-1:0] DRAIN_INIT = DCW'(drainCycles);
  localparam logic [KW-1:0]  LAST_RES   = KW'(k - 1);

  state_t               r_state;
  state_t               w_next;
  logic                 w_accept;
  logic                 w_vec_end;
  logic                 w_beat_first;
  logic [VEC_CNT_W-1:0] w_vec_cnt;
  logic [DCW-1:0]       r_drain;
  logic [KW-1:0]        r_res_cnt;
  logic                 r_wr_en;
  logic [DW-1:0]        r_wr_data;
  logic                 r_core_done;
  logic                 r_error;
  logic                 r_out_valid;
  logic [31:0]          r_out_name;
  logic [31:0]          r_out_value;
  logic                 w_out_hs;

  assign w_accept         = in_valid & in_ready;
  assign w_out_hs         = (r_state == S_READ_HOLD) & r_out_valid & out_ready;
  assign core_wr_en       = r_wr_en;
  assign core_dataValueIn = r_wr_data;
  assign core_done        = r_core_done;
  assign error            = r_error;
  assign out_valid        = r_out_valid;
  assign out_name         = r_out_name;
  assign out_value        = r_out_value;
  assign out_last         = r_out_valid & (r_res_cnt == LAST_RES);

  knn_beat_counter #(
    .numberOfDimensions(numberOfDimensions)
  ) u_beat_counter (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (r_state == S_ARM),
    .i_beat       (w_accept),
    .i_vec_en     (r_state == S_LOAD_TRAIN),
    .o_vec_cnt    (w_vec_cnt),
    .o_vec_end    (w_vec_end),
    .o_beat_first (w_beat_first)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a stray in_last anywhere but a training-vector end is a protocol error
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (cmd_start) w_next = S_ARM;
      S_ARM:        w_next = S_LOAD_REF;
      S_LOAD_REF: begin
        if (w_accept) begin
          if (in_last)        w_next = S_ERR;
          else if (w_vec_end) w_next = S_LOAD_TRAIN;
        end
      end
      S_LOAD_TRAIN: if (w_accept && in_last) w_next = w_vec_end ? S_DRAIN : S_ERR;
      S_DRAIN:      if (r_drain == '0) w_next = S_FINISH;
      S_FINISH:     w_next = S_READ_REQ;
      S_READ_REQ:   w_next = S_READ_HOLD;
      S_READ_HOLD:  if (w_out_hs) w_next = (r_res_cnt == LAST_RES) ? S_IDLE : S_READ_REQ;
      S_ERR:        if (cmd_start) w_next = S_ARM;
      default:      w_next = S_IDLE;
    endcase
  end

  // Level and strobe outputs decoded from the current state
  always_comb begin
    in_ready   = 1'b0;
    core_start = 1'b0;
    core_rd_en = 1'b0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_ARM, S_DRAIN, S_FINISH, S_READ_HOLD: core_start = 1'b1;
      S_LOAD_REF, S_LOAD_TRAIN: begin
        core_start = 1'b1;
        in_ready   = 1'b1;
      end
      S_READ_REQ: begin
        core_start = 1'b1;
        core_rd_en = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered write path; the beat that triggers an error is never forwarded to the core
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_en   <= 1'b0;
      r_wr_data <= '0;
    end else begin
      r_wr_en <= w_accept && (w_next != S_ERR);
      if (w_accept) r_wr_data <= in_data;
    end
  end

  // Drain countdown, re-armed at every training-vector start so it is ready when in_last lands
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drain <= '0;
    end else if (r_state == S_LOAD_TRAIN && w_beat_first) begin
      r_drain <= DRAIN_INIT;
    end else if (r_state == S_DRAIN && r_drain != '0) begin
      r_drain <= r_drain - 1'b1;
    end
  end

  // core_done rises on leaving FINISH and stays up until the run ends
  always_ff @(posedge clk) begin
    if (reset) begin
      r_core_done <= 1'b0;
    end else if (r_state == S_FINISH) begin
      r_core_done <= 1'b1;
    end else if (w_next == S_IDLE || w_next == S_ERR || w_next == S_ARM) begin
      r_core_done <= 1'b0;
    end
  end

  // Sticky error flag, cleared only when a new run is armed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if (w_next == S_ERR) begin
      r_error <= 1'b1;
    end else if (w_next == S_ARM) begin
      r_error <= 1'b0;
    end
  end

  // Result capture one cycle after the read strobe, held until the consumer takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_name  <= '0;
      r_out_value <= '0;
      r_res_cnt   <= '0;
    end else begin
      if (r_state == S_ARM) r_res_cnt <= '0;
      else if (w_out_hs)    r_res_cnt <= r_res_cnt + 1'b1;
      if (r_state == S_READ_HOLD && !r_out_valid) begin
        r_out_valid <= 1'b1;
        r_out_name  <= core_dataNameOut;
        r_out_value <= core_dataValueOut;
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef KNN_CTRL_PERF_EN
  logic [PERF_W-1:0] r_perf_cycles;
  logic [PERF_W-1:0] r_perf_vectors;

  assign perf_cycles  = r_perf_cycles;
  assign perf_vectors = r_perf_vectors;

  // Run length and training-vector tally, frozen while idle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_cycles  <= '0;
      r_perf_vectors <= '0;
    end else if (r_state == S_ARM) begin
      r_perf_cycles  <= PERF_W'(1);
      r_perf_vectors <= '0;
    end else if (r_state != S_IDLE) begin
      r_perf_cycles  <= r_perf_cycles + 1'b1;
      r_perf_vectors <= PERF_W'(w_vec_cnt);
    end
  end
`else
  logic w_unused_vec_cnt;
  assign w_unused_vec_cnt = ^w_vec_cnt;
`endif

endmodule

// File: tb/tb_knn_seq_ctrl.sv
// tb/tb_knn_seq_ctrl.sv - scoreboard bench for knn_seq_ctrl
module tb_knn_seq_ctrl;

  localparam int DW = 32;
  localparam int ND = 5;
  localparam int NC = 2;
  localparam int K  = 3;
  localparam int DR = 10;
  localparam int BW = NC * DW;

  typedef struct {
    logic [31:0] name;
    logic [31:0] value;
    logic        last;
  } res_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic [BW-1:0] in_data = '0;
  logic [31:0]   core_dataNameOut = '0;
  logic [31:0]   core_dataValueOut = '0;
  logic          in_ready, core_start, core_wr_en, core_done, core_rd_en;
  logic          out_valid, out_last, busy, error;
  logic [BW-1:0] core_dataValueIn;
  logic [31:0]   out_name, out_value;
`ifdef KNN_CTRL_PERF_EN
  logic [31:0]   perf_cycles, perf_vectors;
`endif

  always #5 clk = ~clk;

  knn_seq_ctrl #(
    .dataWidth(DW), .numberOfDimensions(ND), .numberOfChannels(NC), .k(K), .drainCycles(DR)
  ) dut (
    .clk(clk), .reset(reset), .cmd_start(cmd_start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .core_start(core_start), .core_wr_en(core_wr_en), .core_dataValueIn(core_dataValueIn),
    .core_done(core_done), .core_rd_en(core_rd_en),
    .core_dataNameOut(core_dataNameOut), .core_dataValueOut(core_dataValueOut),
    .out_valid(out_valid), .out_ready(out_ready), .out_name(out_name), .out_value(out_value),
    .out_last(out_last), .busy(busy), .error(error)
`ifdef KNN_CTRL_PERF_EN
    , .perf_cycles(perf_cycles), .perf_vectors(perf_vectors)
`endif
  );

  int            checks = 0;
  int            errors = 0;
  logic [BW-1:0] exp_wr[$];
  res_t          exp_res[$];
  int            rd_seen = 0;
  int            done_rises = 0;
  int            busy_cycles = 0;
  logic          prev_done = 1'b0;
  int            rd_idx = 0;
  time           done_rise_time = 0;
  time           last_accept_time = 0;
  time           cmd_time = 0;
  logic [BW-1:0] mon_wr;
  res_t          mon_res;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] res_name(input int i);
    return 32'h100 + 32'(i);
  endfunction

  function automatic logic [31:0] res_value(input int i);
    return 32'd40 + 32'(i * 13);
  endfunction

  // Reference beats are {ch0,ch1} = {0,1},{0,2},{0,2},{0,2},{0,3}; training beats are a fixed pattern
  function automatic logic [BW-1:0] beat_data(input int n);
    logic [31:0] a;
    logic [31:0] b;
    if (n < ND) begin
      a = 32'd0;
      b = (n == 0) ? 32'd1 : (n == ND - 1) ? 32'd3 : 32'd2;
    end else begin
      a = 32'(n * 3);
      b = 32'h1000 + 32'(n);
    end
    return {b, a};
  endfunction

  // Behavioural core read port: registered result after each rd_en
  always @(posedge clk) begin
    if (core_rd_en) begin
      core_dataNameOut  <= res_name(rd_idx);
      core_dataValueOut <= res_value(rd_idx);
      rd_idx            <= (rd_idx + 1) % K;
    end
  end

  // Monitor: pops the scoreboard on every write and every result handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (core_wr_en) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL wr_unexpected: got %0h expected no write", core_dataValueIn);
        end else begin
          mon_wr = exp_wr.pop_front();
          chk("wr_data", core_dataValueIn, mon_wr);
        end
      end
      if (core_rd_en) rd_seen++;
      if (core_done && !prev_done) begin
        done_rises++;
        done_rise_time = $time;
      end
      if (busy) busy_cycles++;
      if (out_valid && out_ready) begin
        if (exp_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL res_unexpected: got %0h expected no result", out_name);
        end else begin
          mon_res = exp_res.pop_front();
          chk("res_name", out_name, mon_res.name);
          chk("res_value", out_value, mon_res.value);
          chk("res_last", out_last, mon_res.last);
        end
      end
    end
    prev_done = core_done;
  end

  task automatic check_idle(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_wr_en"}, core_wr_en, 0);
    chk({tag, "_core_data"}, core_dataValueIn, 0);
    chk({tag, "_core_done"}, core_done, 0);
    chk({tag, "_core_rd_en"}, core_rd_en, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_name"}, out_name, 0);
    chk({tag, "_out_value"}, out_value, 0);
    chk({tag, "_out_last"}, out_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_error"}, error, 0);
  endtask

  task automatic start_run();
    cmd_start = 1'b1;
    @(posedge clk);
    cmd_time = $time;
    #1 cmd_start = 1'b0;
    @(negedge clk);
    chk("arm_core_start", core_start, 1);
    chk("arm_error_clear", error, 0);
    chk("arm_in_ready", in_ready, 0);
  endtask

  task automatic send_beat(input logic [BW-1:0] d, input logic last, input bit gaps);
    int t;
    if (gaps && $urandom_range(1) == 1) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    t = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 50) begin
        chk("accept_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    last_accept_time = $time;
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // err_at (1-based) names the beat that must not reach the core; 0 for none
  task automatic run_beats(input int nbeats, input int err_at, input bit gaps);
    for (int n = 0; n < nbeats; n++) begin
      if (n + 1 != err_at) exp_wr.push_back(beat_data(n));
      send_beat(beat_data(n), n == nbeats - 1, gaps);
      if (n == 0 && !gaps) chk("first_beat_latency", (last_accept_time - cmd_time) / 10, 2);
    end
  endtask

  task automatic read_results(input int hold_idx);
    int t;
    int rd_base;
    rd_base = rd_seen;
    for (int i = 0; i < K; i++) begin
      exp_res.push_back('{res_name(i), res_value(i), i == K - 1});
      t = 0;
      forever begin
        @(negedge clk);
        if (out_valid) break;
        t++;
        if (t > 100) begin
          chk("out_valid_timeout", 0, 1);
          break;
        end
      end
      chk("read_pulses", rd_seen - rd_base, i + 1);
      if (i == hold_idx) begin
        repeat (7) begin
          @(negedge clk);
          chk("hold_valid", out_valid, 1);
          chk("hold_name", out_name, res_name(i));
          chk("hold_value", out_value, res_value(i));
          chk("hold_rd_pulses", rd_seen - rd_base, i + 1);
        end
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
    @(negedge clk);
    chk("busy_after_read", busy, 0);
    chk("read_total", rd_seen - rd_base, K);
  endtask

  task automatic full_run(input bit gaps, input int hold_idx);
    int done_base;
    done_base = done_rises;
    start_run();
    run_beats(4 * ND, 0, gaps);
    read_results(hold_idx);
    chk("done_latency", (done_rise_time - 5 - last_accept_time) / 10, DR + 2);
    chk("done_rises", done_rises - done_base, 1);
    chk("wr_queue_empty", exp_wr.size(), 0);
    chk("res_queue_empty", exp_res.size(), 0);
  endtask

  task automatic error_run(input int nbeats);
    int done_base;
    done_base = done_rises;
    start_run();
    run_beats(nbeats, nbeats, 0);
    @(negedge clk);
    chk("err_flag", error, 1);
    chk("err_in_ready", in_ready, 0);
    chk("err_core_start", core_start, 0);
    chk("err_wr_en", core_wr_en, 0);
    chk("err_busy", busy, 1);
    repeat (20) @(negedge clk);
    chk("err_sticky", error, 1);
    chk("err_no_done", done_rises - done_base, 0);
    chk("err_wr_queue_empty", exp_wr.size(), 0);
  endtask

  task automatic reset_in_drain();
    int done_base;
    done_base = done_rises;
    start_run();
    run_beats(4 * ND, 0, 0);
    repeat (3) @(negedge clk);
    chk("drain_core_start", core_start, 1);
    chk("drain_core_done", core_done, 0);
    chk("drain_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_idle("midreset");
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_no_done", done_rises - done_base, 0);
    chk("midreset_wr_queue_empty", exp_wr.size(), 0);
  endtask

  initial begin
    int busy_base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clk);

    busy_base = busy_cycles;
    full_run(0, -1);
`ifdef KNN_CTRL_PERF_EN
    chk("perf_vectors", perf_vectors, 3);
    chk("perf_cycles", perf_cycles, busy_cycles - busy_base);
`else
    chk("run_cycles_nonzero", busy_cycles - busy_base > 0, 1);
`endif

    full_run(0, 1);

    error_run(8);
    full_run(0, -1);

    error_run(ND);
    full_run(0, -1);

    reset_in_drain();
    full_run(1, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule
